// File: rtl/alu_ctrl_pkg.sv
// Shared types and helpers for the sliced-ALU sequencer: FSM encoding,
// default mode width and a constant-foldable ceil(log2) for counter sizing.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MODE_W_DEF = 3;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request/response bus of the sequencer. Both channels use valid/ready: a
// transfer happens on a rising edge where valid and ready are both high; the
// sender holds its payload stable while valid is high and ready is low.
interface alu_slice_sequencer_if #(
  parameter int N      = 4,
  parameter int SLICES = 4,
  parameter int MODE_W = 3
);
  localparam int W = N * SLICES;

  logic              req_valid;
  logic              req_ready;
  logic [W-1:0]      req_a;
  logic [W-1:0]      req_b;
  logic [MODE_W-1:0] req_mode;
  logic              req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_result;
  logic              rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_mode, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mode, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout
  );
endinterface

// File: rtl/alu_slice_mux.sv
// Selects the N-bit slice number idx out of a W-bit operand.
module alu_slice_mux
  import alu_ctrl_pkg::*;
#(
  parameter int N      = 4,
  parameter int SLICES = 4,
  localparam int W     = N * SLICES,
  localparam int CNT_W = clog2(SLICES)
) (
  input  logic [W-1:0]     data,
  input  logic [CNT_W-1:0] idx,
  output logic [N-1:0]     slice
);
  assign slice = data[idx*N +: N];
endmodule

// File: rtl/alu_slice_sequencer.sv
// Runs a W-bit operation through an external combinational N-bit ALU, one
// slice per clock, LSB first, chaining carry-out into the next carry-in.
module alu_slice_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int N      = 4,
  parameter int SLICES = 4,
  parameter int MODE_W = MODE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_slice_sequencer_if.slave   bus,
  output logic                   busy,
  output logic [N-1:0]           alu_a,
  output logic [N-1:0]           alu_b,
  output logic                   alu_cin,
  output logic [MODE_W-1:0]      alu_mode,
  input  logic [N-1:0]           alu_result,
  input  logic                   alu_cout,
  output state_t                 dbg_state
);
  localparam int W     = N * SLICES;
  localparam int CNT_W = clog2(SLICES);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  idx;
  logic              carry;
  logic [W-1:0]      a_reg, b_reg, result_reg;
  logic [MODE_W-1:0] mode_reg;
  logic              cout_reg;
  logic [N-1:0]      a_slice, b_slice;
  logic              accept, last, in_run;

  assign in_run = (state == RUN);
  assign last   = (idx == CNT_W'(SLICES - 1));
  assign accept = bus.req_valid && bus.req_ready;

  alu_slice_mux #(.N(N), .SLICES(SLICES)) u_mux_a (.data(a_reg), .idx(idx), .slice(a_slice));
  alu_slice_mux #(.N(N), .SLICES(SLICES)) u_mux_b (.data(b_reg), .idx(idx), .slice(b_slice));

  // ALU inputs are parked at zero outside RUN so idle cycles are quiet.
  assign alu_a    = in_run ? a_slice  : '0;
  assign alu_b    = in_run ? b_slice  : '0;
  assign alu_cin  = in_run ? carry    : 1'b0;
  assign alu_mode = in_run ? mode_reg : '0;

  assign bus.req_ready  = rst_n && (state == IDLE);
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_result = result_reg;
  assign bus.rsp_cout   = cout_reg;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      carry      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      mode_reg   <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else if (state == IDLE && accept) begin
      a_reg    <= bus.req_a;
      b_reg    <= bus.req_b;
      mode_reg <= bus.req_mode;
      carry    <= bus.req_cin;
      idx      <= '0;
    end else if (in_run) begin
      // Only the current slice is written; other bits keep their old value.
      result_reg[idx*N +: N] <= alu_result;
      carry                  <= alu_cout;
      if (last) cout_reg <= alu_cout;
      else      idx      <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer with an adder stub as the ALU; expected
// results come from whole-word arithmetic on the operands.
module tb_alu_slice_sequencer;
  import alu_ctrl_pkg::*;

  localparam int N      = 4;
  localparam int SLICES = 4;
  localparam int MODE_W = 3;
  localparam int W      = N * SLICES;

  logic              clk;
  logic              rst_n;
  logic              busy;
  logic [N-1:0]      alu_a, alu_b, alu_result;
  logic              alu_cin, alu_cout;
  logic [MODE_W-1:0] alu_mode;
  state_t            dbg_state;

  alu_slice_sequencer_if #(.N(N), .SLICES(SLICES), .MODE_W(MODE_W)) bus ();

  alu_slice_sequencer #(.N(N), .SLICES(SLICES), .MODE_W(MODE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .dbg_state  (dbg_state)
  );

  // Stub ALU: plain adder, mode ignored.
  assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Carry into slice k is the carry out of the low k*N bits of the full sum.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int k);
    logic [63:0] mask, s;
    mask = (64'd1 << (k * N)) - 64'd1;
    s = ({48'd0, a} & mask) + ({48'd0, b} & mask) + {63'd0, cin};
    return s[k*N];
  endfunction

  // ---------------- driver ----------------
  // Issues one request, checks every RUN cycle, the response, and (after
  // hold cycles of backpressure) the handshake back to IDLE. When preload is
  // set, the next request is presented on the bus during the DONE wait.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [MODE_W-1:0] mode, input logic cin,
                        input int hold, input bit preload,
                        input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W:0] exp, full;
    @(negedge clk);
    check("idle_req_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_mode  = mode;
    bus.req_cin   = cin;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_q.push_back(full);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    for (int k = 0; k < SLICES; k++) begin
      @(negedge clk);
      check("run_busy",     busy, 1'b1);
      check("run_rsp_valid", bus.rsp_valid, 1'b0);
      check("run_alu_a",    alu_a, (a >> (k * N)) & 16'hF);
      check("run_alu_b",    alu_b, (b >> (k * N)) & 16'hF);
      check("run_alu_cin",  alu_cin, carry_into(a, b, cin, k));
      check("run_alu_mode", alu_mode, mode);
      check("run_req_ready", bus.req_ready, 1'b0);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    check("done_rsp_valid", bus.rsp_valid, 1'b1);
    check("done_result",    bus.rsp_result, exp[W-1:0]);
    check("done_cout",      bus.rsp_cout, exp[W]);
    check("done_alu_mode",  alu_mode, '0);
    check("done_req_ready", bus.req_ready, 1'b0);
    if (preload) begin
      bus.req_valid = 1'b1;
      bus.req_a     = na;
      bus.req_b     = nb;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 1'b1);
      check("hold_result",    bus.rsp_result, exp[W-1:0]);
      check("hold_cout",      bus.rsp_cout, exp[W]);
      check("hold_req_ready", bus.req_ready, 1'b0);
      check("hold_busy",      busy, 1'b1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 1'b0);
    check("post_busy",      busy, 1'b0);
    check("post_alu_mode",  alu_mode, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb, na, nb;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_mode  = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_alu_a",     alu_a, '0);
    check("rst_alu_b",     alu_b, '0);
    check("rst_alu_mode",  alu_mode, '0);
    check("rst_busy",      busy, 1'b0);
    check("rst_result",    bus.rsp_result, '0);
    check("rst_cout",      bus.rsp_cout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_req_ready", bus.req_ready, 1'b1);

    // Carry chain across the two low slices.
    run_op(16'h00FF, 16'h0001, 3'b000, 1'b0, 0, 1'b0, '0, '0);
    // Full overflow through every slice.
    run_op(16'hFFFF, 16'h0000, 3'b000, 1'b1, 0, 1'b0, '0, '0);
    // Backpressure with the next request already waiting, then that request.
    na = 16'h1234;
    nb = 16'hEDCC;
    bus.req_mode = 3'b101;
    bus.req_cin  = 1'b0;
    run_op(16'hA5A5, 16'h5A5B, 3'b010, 1'b1, 5, 1'b1, na, nb);
    check("second_accept_ready", bus.req_ready, 1'b1);
    run_op(na, nb, 3'b101, 1'b0, 0, 1'b0, '0, '0);

    // Randomised operations.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, MODE_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b0, '0, '0);
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = 16'h0F0F;
    bus.req_b     = 16'h0101;
    bus.req_mode  = 3'b011;
    bus.req_cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_alu_a_slice2", alu_a, 4'hF);
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",      busy, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    check("midrst_req_ready", bus.req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("after_rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("after_rst_req_ready", bus.req_ready, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
